// File: rtl/pdm_sample_scheduler.sv
// Sample scheduler feeding a delta-sigma modulator: buffers PCM words in a small
// FIFO, primes it, then releases one word every OSR clocks and flags missed slots.
module pdm_sample_scheduler #(
    parameter int unsigned OSR   = 8,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PRIME = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic                     byte_swap,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [15:0]              s_data,
    output logic [15:0]              mod_data,
    output logic                     mod_load,
    output logic                     running,
    output logic                     underrun,
    output logic [7:0]               underrun_cnt,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned PW = $clog2(OSR);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [15:0]     mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [PW-1:0]   phase;
    logic [15:0]     wdata;
    logic            full;
    logic            push;
    logic            slot;
    logic            pop;
    logic            miss;
    logic            flush;
    logic            clear_cnt;

    // Handshake and slot strobes derive only from registered state, never from s_valid/s_data paths to outputs
    assign full      = (level == LW'(DEPTH));
    assign s_ready   = (state_q != ST_IDLE) && !full;
    assign running   = (state_q == ST_RUN);
    assign push      = s_valid && s_ready && enable;
    assign slot      = (state_q == ST_RUN) && enable && (phase == PW'(OSR - 1));
    assign pop       = slot && (level != '0);
    assign miss      = slot && (level == '0);
    assign flush     = !enable;
    assign clear_cnt = (state_q == ST_IDLE) && enable;
    assign wdata     = byte_swap ? {s_data[7:0], s_data[15:8]} : s_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  state_d = ST_PRIME;
                ST_PRIME: if (level >= LW'(PRIME)) state_d = ST_RUN;
                ST_RUN:   state_d = ST_RUN;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // Sample storage; contents are don't-care outside the occupied window
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level        <= '0;
            phase        <= '0;
            mod_data     <= 16'h0000;
            mod_load     <= 1'b0;
            underrun     <= 1'b0;
            underrun_cnt <= 8'd0;
        end else begin
            mod_load <= pop;
            underrun <= miss;
            if (flush) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                level    <= '0;
                phase    <= '0;
                mod_data <= 16'h0000;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop) begin
                    rd_ptr   <= rd_ptr + AW'(1);
                    mod_data <= mem[rd_ptr];
                end
                if (push && !pop) begin
                    level <= level + LW'(1);
                end else if (pop && !push) begin
                    level <= level - LW'(1);
                end
                // Phase only advances in RUN so the first slot lands OSR clocks after entry
                if (state_q == ST_RUN) begin
                    phase <= (phase == PW'(OSR - 1)) ? '0 : phase + PW'(1);
                end else begin
                    phase <= '0;
                end
            end
            if (clear_cnt) begin
                underrun_cnt <= 8'd0;
            end else if (miss && (underrun_cnt != 8'hFF)) begin
                underrun_cnt <= underrun_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_pdm_sample_scheduler.sv
// Bench for pdm_sample_scheduler: scoreboard of pushed samples checked at each
// mod_load, plus timed sequences for priming, underrun, flush and async reset.
module tb_pdm_sample_scheduler;

    localparam int unsigned OSR   = 8;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned PRIME = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        byte_swap;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] s_data;
    logic [15:0] mod_data;
    logic        mod_load;
    logic        running;
    logic        underrun;
    logic [7:0]  underrun_cnt;
    logic [2:0]  level;

    always #5 clk = ~clk;

    pdm_sample_scheduler #(.OSR(OSR), .DEPTH(DEPTH), .PRIME(PRIME)) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .byte_swap    (byte_swap),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .mod_data     (mod_data),
        .mod_load     (mod_load),
        .running      (running),
        .underrun     (underrun),
        .underrun_cnt (underrun_cnt),
        .level        (level)
    );

    typedef struct {
        logic        swap;
        logic [15:0] din;
        logic [15:0] exp;
    } vec_t;

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc   = 0;
    logic [15:0] sbq[$];
    int          load_cyc[$];
    int          under_cyc[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Advance to the next falling edge and score any sample the DUT presented
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (mod_load === 1'b1) begin
            load_cyc.push_back(cyc);
            check("mod_load_expected", 32'(sbq.size() != 0), 1);
            if (sbq.size() != 0) check("mod_data_order", 32'(mod_data), 32'(sbq.pop_front()));
        end
        if (underrun === 1'b1) under_cyc.push_back(cyc);
    endtask

    task automatic tick_to(input int target);
        while (cyc < target) tick();
    endtask

    task automatic push_word(input logic sw, input logic [15:0] d, input logic [15:0] e);
        int g;
        g = 0;
        byte_swap = sw;
        s_data    = d;
        s_valid   = 1'b1;
        while (s_ready !== 1'b1 && g < 200) begin
            check("full_blocks_ready", 32'(level), DEPTH);
            tick();
            g++;
        end
        check("push_accepted", 32'(s_ready), 1);
        if (s_ready === 1'b1) sbq.push_back(e);
        tick();
        s_valid = 1'b0;
    endtask

    task automatic wait_running(input int bound, output int at);
        int g;
        g = 0;
        while (running !== 1'b1 && g < bound) begin
            tick();
            g++;
        end
        check("running_within_bound", 32'(running), 1);
        at = cyc;
    endtask

    task automatic drain(input int bound);
        int g;
        g = 0;
        while (sbq.size() != 0 && g < bound) begin
            tick();
            g++;
        end
        check("scoreboard_drained", 32'(sbq.size()), 0);
    endtask

    initial begin
        vec_t        vecs[6];
        int          t_run;
        int          acc;
        int          bad;
        int          maxlvl;
        int          g;
        int          prev;
        logic [15:0] d;

        vecs[0] = '{1'b0, 16'h1234, 16'h1234};
        vecs[1] = '{1'b1, 16'h3412, 16'h1234};
        vecs[2] = '{1'b1, 16'h00FF, 16'hFF00};
        vecs[3] = '{1'b0, 16'h8000, 16'h8000};
        vecs[4] = '{1'b1, 16'hABCD, 16'hCDAB};
        vecs[5] = '{1'b0, 16'hFFFF, 16'hFFFF};

        rst = 1'b1; enable = 1'b0; byte_swap = 1'b0; s_valid = 1'b0; s_data = 16'h0;
        #1;
        check("rst_running", 32'(running), 0);
        check("rst_s_ready", 32'(s_ready), 0);
        check("rst_level", 32'(level), 0);
        check("rst_mod_data", 32'(mod_data), 0);
        check("rst_mod_load", 32'(mod_load), 0);
        check("rst_underrun", 32'(underrun), 0);
        check("rst_underrun_cnt", 32'(underrun_cnt), 0);
        tick(); tick();
        rst = 1'b0;
        tick();
        check("idle_s_ready", 32'(s_ready), 0);

        // Prime with two words, then check slot timing relative to RUN entry
        enable = 1'b1;
        tick();
        check("prime_s_ready", 32'(s_ready), 1);
        check("prime_running", 32'(running), 0);
        push_word(1'b0, 16'h1234, 16'h1234);
        push_word(1'b0, 16'h5678, 16'h5678);
        load_cyc.delete();
        wait_running(10, t_run);
        check("run_entry_level", 32'(level), 2);
        tick_to(t_run + 17);
        check("first_loads_count", 32'(load_cyc.size()), 2);
        check("first_load_cycle", 32'(load_cyc.size() > 0 ? load_cyc[0] - t_run : -1), OSR);
        check("second_load_cycle", 32'(load_cyc.size() > 1 ? load_cyc[1] - t_run : -1), 2 * OSR);
        tick_to(t_run + 24);
        check("underrun_pulse_1", 32'(underrun), 1);
        check("underrun_cnt_1", 32'(underrun_cnt), 1);
        check("mod_data_held", 32'(mod_data), 32'h5678);
        tick();
        check("underrun_one_cycle", 32'(underrun), 0);
        tick_to(t_run + 32);
        check("underrun_cnt_2", 32'(underrun_cnt), 2);

        // Byte-swap table, overflowing the FIFO so ready back-pressure is exercised
        foreach (vecs[i]) push_word(vecs[i].swap, vecs[i].din, vecs[i].exp);
        drain(200);
        check("table_level_empty", 32'(level), 0);

        // Continuous source: one accept per OSR clocks once full, no loss
        d = 16'h0100; acc = 0; bad = 0; maxlvl = 0;
        byte_swap = 1'b0;
        for (int i = 0; i < 104; i++) begin
            s_valid = 1'b1;
            s_data  = d;
            if (i == 40) acc = 0;
            if ((level == 3'(DEPTH)) == (s_ready === 1'b1)) bad++;
            if (int'(level) > maxlvl) maxlvl = int'(level);
            if (s_ready === 1'b1) begin
                sbq.push_back(d);
                d = d + 16'd1;
                acc++;
            end
            tick();
        end
        s_valid = 1'b0;
        check("steady_accepts_per_64", 32'(acc), 64 / OSR);
        check("ready_equals_not_full", 32'(bad), 0);
        check("level_peak", 32'(maxlvl), DEPTH);
        drain(100);

        // Re-arm, play three words, then count missed slots up to saturation
        enable = 1'b0;
        tick();
        check("idle_after_disable", 32'(running), 0);
        enable = 1'b1;
        tick();
        check("cnt_cleared_on_prime", 32'(underrun_cnt), 0);
        load_cyc.delete();
        push_word(1'b0, 16'hA001, 16'hA001);
        push_word(1'b0, 16'hA002, 16'hA002);
        push_word(1'b0, 16'hA003, 16'hA003);
        prev = 0;
        for (int k = 1; k <= 3; k++) begin
            g = 0;
            do begin
                tick();
                g++;
            end while (underrun !== 1'b1 && g < 60);
            check("underrun_seq_pulse", 32'(underrun), 1);
            check("underrun_seq_cnt", 32'(underrun_cnt), 32'(k));
            check("underrun_seq_hold", 32'(mod_data), 32'hA003);
            if (k > 1) check("underrun_spacing", 32'(cyc - prev), OSR);
            prev = cyc;
        end
        check("three_loads", 32'(load_cyc.size()), 3);
        tick_to(cyc + 2030);
        check("underrun_cnt_saturated", 32'(underrun_cnt), 255);
        g = 0;
        do begin
            tick();
            g++;
        end while (underrun !== 1'b1 && g < 10);
        check("saturated_pulse", 32'(underrun), 1);
        check("saturated_hold", 32'(underrun_cnt), 255);

        // Flush with three buffered words while a sample is on mod_data
        push_word(1'b0, 16'hB001, 16'hB001);
        push_word(1'b0, 16'hB002, 16'hB002);
        push_word(1'b0, 16'hB003, 16'hB003);
        check("pre_flush_level", 32'(level), 3);
        enable = 1'b0;
        tick();
        sbq.delete();
        check("flush_running", 32'(running), 0);
        check("flush_level", 32'(level), 0);
        check("flush_mod_data", 32'(mod_data), 0);
        check("flush_s_ready", 32'(s_ready), 0);
        check("flush_cnt_kept", 32'(underrun_cnt), 255);
        enable = 1'b1;
        tick();
        check("reenable_cnt_cleared", 32'(underrun_cnt), 0);
        check("reenable_level", 32'(level), 0);
        push_word(1'b0, 16'hC001, 16'hC001);
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (running !== 1'b0) bad++;
        end
        check("prime_needs_two", 32'(bad), 0);
        push_word(1'b0, 16'hC002, 16'hC002);
        wait_running(5, t_run);
        tick_to(t_run + OSR + 3);
        check("pre_reset_mod_data", 32'(mod_data), 32'hC001);

        // Asynchronous reset between slot events
        #2 rst = 1'b1;
        #1;
        check("async_running", 32'(running), 0);
        check("async_s_ready", 32'(s_ready), 0);
        check("async_level", 32'(level), 0);
        check("async_mod_data", 32'(mod_data), 0);
        check("async_mod_load", 32'(mod_load), 0);
        check("async_underrun", 32'(underrun), 0);
        check("async_cnt", 32'(underrun_cnt), 0);
        sbq.delete();
        tick();
        rst = 1'b0;
        tick_to(cyc + 20);
        check("post_reset_prime", 32'(running), 0);
        check("post_reset_ready", 32'(s_ready), 1);
        check("post_reset_level", 32'(level), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pdm_sample_scheduler.md
PDM_SAMPLE_SCHEDULER -- requirements
Module: pdm_sample_scheduler

Interface
REQ-001 SHALL have parameter OSR, default 8: clocks per PCM sample presented to delta_sigma (legal 2..256).
REQ-002 SHALL have parameter DEPTH, default 4: sample FIFO depth (power of two, 2..16).
REQ-003 SHALL have parameter PRIME, default 2: FIFO level required to leave PRIME (1..DEPTH).
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 enable  in  1  level; 1 = run playback, 0 = mute and flush.
REQ-007 byte_swap  in  1  1 = swap s_data[15:8] and s_data[7:0] at FIFO write; sampled per accepted word.
REQ-008 s_valid  in  1  upstream sample valid.
REQ-009 s_ready  out  1  upstream ready; transfer when s_valid & s_ready.
REQ-010 s_data  in  16  PCM sample, two's complement after optional swap.
REQ-011 mod_data  out  16  registered sample driving delta_sigma data input.
REQ-012 mod_load  out  1  one-cycle pulse, high in the cycle mod_data takes a new FIFO value.
REQ-013 running  out  1  high while state is RUN.
REQ-014 underrun  out  1  one-cycle pulse per missed sample slot.
REQ-015 underrun_cnt  out  8  saturating missed-slot count.
REQ-016 level  out  log2(DEPTH)+1  current FIFO occupancy.

Function
REQ-017 SHALL implement states IDLE, PRIME, RUN.
REQ-018 IDLE: FIFO held empty, s_ready=0, phase counter=0, mod_data=0; enable=1 -> PRIME next cycle.
REQ-019 PRIME: s_ready=!full, phase counter held 0, mod_data unchanged; level>=PRIME -> RUN next cycle; enable=0 -> IDLE.
REQ-020 RUN: phase counter counts 0..OSR-1 and wraps; slot event when phase==OSR-1.
REQ-021 On slot event with level>0: pop head, mod_data<=head, mod_load=1 on the following cycle (aligned with new mod_data).
REQ-022 On slot event with level==0: mod_data held at last value, underrun pulse on following cycle, underrun_cnt+1 saturating at 255, state stays RUN.
REQ-023 First mod_load after entering RUN SHALL occur OSR cycles after RUN entry (counter starts at 0).
REQ-024 s_ready SHALL equal !full in PRIME and RUN, combinationally from registered level only (no s_valid dependency).
REQ-025 Simultaneous push and pop in same cycle: both performed, level unchanged; push while full impossible by REQ-024.
REQ-026 FIFO order strict first-in first-out; read/write pointers wrap modulo DEPTH.
REQ-027 enable 1->0 in any state: next cycle IDLE, FIFO flushed (level=0), mod_data=0, phase=0, accepted-but-unplayed samples discarded; underrun_cnt retained.
REQ-028 underrun_cnt cleared only by rst or by IDLE->PRIME transition.
REQ-029 No output SHALL depend combinationally on s_valid or s_data.

Reset
REQ-030 rst asserted: state=IDLE, level=0, pointers=0, phase=0, mod_data=16'h0000, mod_load=0, underrun=0, underrun_cnt=0, running=0, s_ready=0, immediately (asynchronous).
REQ-031 rst deasserted mid-operation: block restarts from IDLE; no partial sample emitted.

Verification
REQ-032 Reset then enable=1, push 16'h1234,16'h5678 (byte_swap=0), OSR=8 -> RUN after level=2; mod_load at RUN+8 with mod_data=16'h1234, RUN+16 with 16'h5678.
REQ-033 byte_swap=1, push 16'h3412 -> mod_data=16'h1234 at its slot.
REQ-034 Continuous s_valid=1 from file-like source -> level saturates at DEPTH, s_ready=0 while full, exactly one accept per OSR cycles in steady state, no sample lost or duplicated.
REQ-035 Stop s_valid after 3 samples in RUN -> 3 mod_loads, then underrun pulses every 8 cycles, mod_data holds last sample, underrun_cnt increments 1,2,3..., saturates at 255.
REQ-036 Drop enable with level=3 -> next cycle IDLE, level=0, mod_data=0; re-enable -> underrun_cnt=0, PRIME requires fresh 2 samples.
REQ-037 Assert rst mid-RUN between slot events -> all outputs to REQ-030 values before next clock edge.
